// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bus, captures the SRAM read word in an
// entry's first cycle, extracts/extends load data and drives writeback and bypass buses.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ex_mem_valid,
    output logic         mem_allowin,
    input  logic [102:0] ex_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic         mem_wb_valid,
    input  logic         wb_allowin,
    output logic [69:0]  mem_wb_bus,
    output logic [37:0]  mem_id_bus
);

    localparam logic [9:0] OP_LD_B  = 10'h0A0;
    localparam logic [9:0] OP_LD_H  = 10'h0A1;
    localparam logic [9:0] OP_LD_BU = 10'h0A8;
    localparam logic [9:0] OP_LD_HU = 10'h0A9;

    logic         mem_valid_q, mem_valid_d;
    logic [102:0] bus_q, bus_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         rdata_held_q, rdata_held_d;

    // Handshake: an entry moves on an edge where the producer's valid and the
    // consumer's allowin are both 1; this stage never stalls on its own (ready_go = 1).
    logic accept;
    assign mem_allowin  = ~mem_valid_q | wb_allowin;
    assign mem_wb_valid = mem_valid_q;
    assign accept       = mem_allowin & ex_mem_valid;

    always_comb begin
        mem_valid_d  = mem_valid_q;
        bus_d        = bus_q;
        rdata_d      = rdata_q;
        rdata_held_d = rdata_held_q;
        if (mem_allowin) begin
            mem_valid_d = ex_mem_valid;
        end
        if (accept) begin
            bus_d        = ex_mem_bus;
            rdata_held_d = 1'b0;
        end else if (mem_valid_q && !rdata_held_q) begin
            rdata_d      = data_sram_rdata;
            rdata_held_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            bus_q        <= '0;
            rdata_q      <= '0;
            rdata_held_q <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            bus_q        <= bus_d;
            rdata_q      <= rdata_d;
            rdata_held_q <= rdata_held_d;
        end
    end

    logic        gr_we, res_from_mem;
    logic [4:0]  dest;
    logic [31:0] pc, result;
    logic [9:0]  load_op;
    logic [1:0]  addr;
    logic        unused_inst_bits;

    assign gr_we            = bus_q[102];
    assign res_from_mem     = bus_q[101];
    assign dest             = bus_q[100:96];
    assign pc               = bus_q[95:64];
    assign load_op          = bus_q[63:54];
    assign unused_inst_bits = ^bus_q[53:32];
    assign result           = bus_q[31:0];
    assign addr             = result[1:0];

    logic [31:0] ld_word, load_data, final_result;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Live SRAM data is only trustworthy in the entry's first cycle; afterwards the copy is used.
    assign ld_word  = rdata_held_q ? rdata_q : data_sram_rdata;
    assign byte_sel = ld_word[{addr, 3'b000} +: 8];
    assign half_sel = addr[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        case (load_op)
            OP_LD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LD_BU: load_data = {24'h0, byte_sel};
            OP_LD_H:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LD_HU: load_data = {16'h0, half_sel};
            default:  load_data = ld_word;
        endcase
    end

    assign final_result = res_from_mem ? load_data : result;
    assign mem_wb_bus   = {gr_we, dest, pc, final_result};
    assign mem_id_bus   = {mem_valid_q & gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage, checked against an entry-level
// reference model of the stage's occupancy and load-result arithmetic.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         ex_mem_valid;
    logic         mem_allowin;
    logic [102:0] ex_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [69:0]  mem_wb_bus;
    logic [37:0]  mem_id_bus;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_mem_valid    (ex_mem_valid),
        .mem_allowin     (mem_allowin),
        .ex_mem_bus      (ex_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_wb_valid    (mem_wb_valid),
        .wb_allowin      (wb_allowin),
        .mem_wb_bus      (mem_wb_bus),
        .mem_id_bus      (mem_id_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model: what entry the stage holds and which SRAM word it saw first
    logic         m_valid = 1'b0;
    logic [102:0] m_bus   = '0;
    logic [31:0]  m_word  = '0;
    bit           m_first = 1'b0;

    logic [9:0] ops [6] = '{10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9, 10'h0B3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [102:0] mk_bus(input logic we, input logic rfm, input logic [4:0] dst,
                                            input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [31:0] res);
        return {we, rfm, dst, pc, inst, res};
    endfunction

    function automatic logic [31:0] ref_final(input logic [102:0] b, input logic [31:0] w);
        int unsigned a    = b[1:0];
        int unsigned op   = b[63:54];
        int unsigned word = w;
        int          byt  = int'((word >> (8 * a)) % 256);
        int          half = int'((word >> (16 * (a / 2))) % 65536);
        if (!b[101]) return b[31:0];
        case (op)
            'h0A0:   return 32'(byt - ((byt >= 128) ? 256 : 0));
            'h0A8:   return 32'(byt);
            'h0A1:   return 32'(half - ((half >= 32768) ? 65536 : 0));
            'h0A9:   return 32'(half);
            default: return w;
        endcase
    endfunction

    task automatic check_outputs(input logic wb);
        chk("mem_allowin", 32'(mem_allowin), 32'(!m_valid || wb));
        chk("mem_wb_valid", 32'(mem_wb_valid), 32'(m_valid));
        chk("mem_bypass", 32'(mem_id_bus[37]), 32'(m_valid && m_bus[102]));
        if (m_valid) begin
            chk("wb_final_result", mem_wb_bus[31:0], ref_final(m_bus, m_word));
            chk("id_final_result", mem_id_bus[31:0], ref_final(m_bus, m_word));
            chk("wb_dest", 32'(mem_wb_bus[68:64]), 32'(m_bus[100:96]));
            chk("wb_pc", mem_wb_bus[63:32], m_bus[95:64]);
            chk("wb_gr_we", 32'(mem_wb_bus[69]), 32'(m_bus[102]));
        end
    endtask

    // driver: one full clock cycle of inputs, checks before the edge, model updated at the edge
    task automatic drive_cycle(input logic v, input logic [102:0] b, input logic wb,
                               input logic [31:0] rd, input bit has_want, input logic [31:0] want,
                               input string tag);
        ex_mem_valid    = v;
        ex_mem_bus      = b;
        wb_allowin      = wb;
        data_sram_rdata = rd;
        if (m_first) m_word = rd;
        #2;
        check_outputs(wb);
        if (has_want) chk(tag, mem_wb_bus[31:0], want);
        @(posedge clk);
        m_first = 1'b0;
        if (!m_valid || wb) begin
            m_valid = v;
            if (v) begin
                m_bus   = b;
                m_first = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] rd);
        drive_cycle(1'b0, '0, 1'b1, rd, 1'b0, '0, "");
    endtask

    initial begin
        logic [102:0] b;
        resetn          = 1'b0;
        ex_mem_valid    = 1'b0;
        ex_mem_bus      = '0;
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'hA5A5_A5A5;
        #3;
        chk("reset_valid", 32'(mem_wb_valid), 32'd0);
        chk("reset_allowin", 32'(mem_allowin), 32'd1);
        chk("reset_bypass", 32'(mem_id_bus[37]), 32'd0);
        chk("reset_wb_bus", mem_wb_bus[31:0], 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ALU pass-through
        drive_cycle(1'b1, mk_bus(1'b1, 1'b0, 5'd5, 32'h1C00_0000, 32'h0010_0000, 32'h1234_5678),
                    1'b1, 32'h0, 1'b0, '0, "");
        drive_cycle(1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, "alu_pass");
        chk("alu_dest", 32'(mem_id_bus[36:32]), 32'd5);

        // ld.b / ld.bu, ld.h / ld.hu directed values
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd7, 32'h1C00_0004, {10'h0A0, 22'h0}, 32'h0000_1003),
                    1'b1, 32'h0, 1'b0, '0, "");
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd8, 32'h1C00_0008, {10'h0A8, 22'h0}, 32'h0000_1003),
                    1'b1, 32'h80FF_0011, 1'b1, 32'hFFFF_FF80, "ld_b");
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd9, 32'h1C00_000C, {10'h0A1, 22'h0}, 32'h0000_2002),
                    1'b1, 32'h80FF_0011, 1'b1, 32'h0000_0080, "ld_bu");
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd10, 32'h1C00_0010, {10'h0A9, 22'h0}, 32'h0000_2002),
                    1'b1, 32'h9ABC_1234, 1'b1, 32'hFFFF_9ABC, "ld_h");
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd11, 32'h1C00_0014, {10'h0A1, 22'h0}, 32'h0000_2003),
                    1'b1, 32'h9ABC_1234, 1'b1, 32'h0000_9ABC, "ld_hu");
        drive_cycle(1'b0, '0, 1'b1, 32'h9ABC_1234, 1'b1, 32'hFFFF_9ABC, "ld_h_odd");

        // stall hold: first-cycle word must persist while rdata changes
        b = mk_bus(1'b1, 1'b1, 5'd12, 32'h1C00_0020, {10'h0A2, 22'h0}, 32'h0000_3000);
        drive_cycle(1'b1, b, 1'b1, 32'h0, 1'b0, '0, "");
        b = mk_bus(1'b1, 1'b1, 5'd13, 32'h1C00_0024, {10'h0A2, 22'h0}, 32'h0000_3004);
        drive_cycle(1'b1, b, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "stall_c0");
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, b, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "stall_hold");
        end
        drive_cycle(1'b1, b, 1'b1, 32'h0, 1'b1, 32'hDEAD_BEEF, "stall_release");
        drive_cycle(1'b0, '0, 1'b1, 32'h2222_2222, 1'b1, 32'h2222_2222, "after_stall");

        // back-to-back word loads
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd1, 32'h1C00_0030, {10'h0A2, 22'h0}, 32'h0000_4000),
                    1'b1, 32'h0, 1'b0, '0, "");
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd2, 32'h1C00_0034, {10'h0A2, 22'h0}, 32'h0000_4004),
                    1'b1, 32'h1111_1111, 1'b1, 32'h1111_1111, "b2b_first");
        drive_cycle(1'b0, '0, 1'b1, 32'h2222_2222, 1'b1, 32'h2222_2222, "b2b_second");

        // async reset in the middle of a stall
        drive_cycle(1'b1, mk_bus(1'b1, 1'b1, 5'd3, 32'h1C00_0040, {10'h0A2, 22'h0}, 32'h0000_5000),
                    1'b1, 32'h0, 1'b0, '0, "");
        drive_cycle(1'b0, '0, 1'b0, 32'h3333_3333, 1'b0, '0, "");
        wb_allowin = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_mid_allowin", 32'(mem_allowin), 32'd1);
        chk("rst_mid_bypass", 32'(mem_id_bus[37]), 32'd0);
        m_valid = 1'b0;
        m_first = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        idle(32'h4444_4444);
        idle(32'h5555_5555);

        // randomized traffic with random stalls and bubbles
        for (int i = 0; i < 200; i++) begin
            logic       v, wb, rfm;
            logic [9:0] op;
            v   = ($urandom_range(0, 3) != 0);
            wb  = ($urandom_range(0, 3) != 0);
            rfm = ($urandom_range(0, 2) != 0);
            op  = rfm ? ops[$urandom_range(0, 5)] : 10'($urandom);
            b   = mk_bus(1'($urandom), rfm, 5'($urandom), $urandom, {op, 22'($urandom)}, $urandom);
            drive_cycle(v, b, wb, $urandom, 1'b0, '0, "");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
